// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: req_size encodings, FSM states,
// the latched request payload and byte-lane helpers.
package dmem_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned BE_W        = 4;
    localparam int unsigned SIZE_W      = 2;

    typedef enum logic [SIZE_W-1:0] {
        SIZE_BYTE     = 2'b00,
        SIZE_HALF     = 2'b01,
        SIZE_WORD     = 2'b10,
        SIZE_WORD_ALT = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        size_e             size;
        logic              is_unsigned;
    } req_t;

    // Lanes touched by an access; half/word ignore the low offset bits.
    function automatic logic [BE_W-1:0] lane_mask(size_e size, logic [1:0] off);
        logic [BE_W-1:0] m;
        case (size)
            SIZE_BYTE: m = 4'b0001 << off;
            SIZE_HALF: m = off[1] ? 4'b1100 : 4'b0011;
            default:   m = 4'b1111;
        endcase
        return m;
    endfunction

    // Replicate right-aligned store data onto every lane it could occupy.
    function automatic logic [WORD_W-1:0] store_lanes(size_e size, logic [WORD_W-1:0] wdata);
        logic [WORD_W-1:0] d;
        case (size)
            SIZE_BYTE: d = {4{wdata[7:0]}};
            SIZE_HALF: d = {2{wdata[15:0]}};
            default:   d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [WORD_W-1:0] load_extend(size_e size, logic [1:0] off,
                                                      logic is_unsigned, logic [WORD_W-1:0] word);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [WORD_W-1:0] d;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: d = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            SIZE_HALF: d = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default:   d = word;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(size_e size, logic [1:0] off);
        logic m;
        case (size)
            SIZE_BYTE: m = 1'b0;
            SIZE_HALF: m = off[0];
            default:   m = (off != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [SIZE_W-1:0] req_size;
    logic              req_unsigned;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_array.sv
// Single-port synchronous word RAM with per-byte write enables; read returns the pre-write word.
module data_mem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [BE_W-1:0]   be_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [BE_W-1:0][7:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0]    rdata_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int b = 0; b < int'(BE_W); b++) begin
                if (we_i && be_i[b]) begin
                    mem_q[addr_i][2'(b)] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store, fixed LATENCY to response.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WAIT_LAST = (LATENCY > 2) ? LATENCY - 2 : 0;
    localparam int unsigned CNT_W     = (WAIT_LAST > 0) ? $clog2(WAIT_LAST + 1) : 1;

    if (LATENCY < LATENCY_MIN || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_param
        $error("data_mem_responder: DEPTH_WORDS must be a power of 2 and LATENCY >= 1");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;

    req_t              live_c;
    req_t              acc_c;
    logic              accept_c;
    logic              enter_resp_c;
    logic              acc_err_c;
    logic              ram_en_c;
    logic              ram_we_c;
    logic [BE_W-1:0]   ram_be_c;
    logic [IDX_W-1:0]  ram_idx_c;
    logic [WORD_W-1:0] ram_wdata_c;
    logic [WORD_W-1:0] ram_rdata;
    logic [WORD_W-1:0] rsp_rdata_c;
    logic              unused_bits_c;

    always_comb begin
        live_c             = '0;
        live_c.write       = bus.req_write;
        live_c.addr        = bus.req_addr;
        live_c.wdata       = bus.req_wdata;
        live_c.size        = size_e'(bus.req_size);
        live_c.is_unsigned = bus.req_unsigned;
    end

    assign accept_c = bus.req_valid && req_ready_q;

    // With LATENCY=1 the RESP-entry edge is the acceptance edge, so the RAM sees the live request.
    assign acc_c = (LATENCY == LATENCY_MIN) ? live_c : req_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign acc_err_c = misaligned(acc_c.size, acc_c.addr[1:0]);
`else
    assign acc_err_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        enter_resp_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    req_d = live_c;
                    cnt_d = '0;
                    if (LATENCY == LATENCY_MIN) begin
                        state_d      = ST_RESP;
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    state_d      = ST_RESP;
                    enter_resp_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
        rsp_err_d   = enter_resp_c ? acc_err_c : (rsp_err_q && (state_d == ST_RESP));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // The array is touched only on the RESP-entry edge, so its read register holds through RESP.
    assign ram_en_c    = enter_resp_c;
    assign ram_we_c    = acc_c.write && !acc_err_c;
    assign ram_be_c    = lane_mask(acc_c.size, acc_c.addr[1:0]);
    assign ram_idx_c   = acc_c.addr[2 +: IDX_W];
    assign ram_wdata_c = store_lanes(acc_c.size, acc_c.wdata);

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .en_i    (ram_en_c),
        .we_i    (ram_we_c),
        .be_i    (ram_be_c),
        .addr_i  (ram_idx_c),
        .wdata_i (ram_wdata_c),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        rsp_rdata_c = '0;
        if (rsp_valid_q && !req_q.write && !rsp_err_q) begin
            rsp_rdata_c = load_extend(req_q.size, req_q.addr[1:0], req_q.is_unsigned, ram_rdata);
        end
    end

    // Address bits above the word index are dropped so addresses wrap.
    assign unused_bits_c = ^{acc_c, req_q};

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_c;
    assign bus.rsp_err   = rsp_err_q;

endmodule
